// File: rtl/insn_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch FIFO.
package insn_fetch_pkg;

  localparam int INSN_W = 16;
  localparam int IP_W   = 16;
  localparam logic [IP_W-1:0] IP_ALIGN_MASK = 16'hFFFE;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [IP_W-1:0]   addr;
    logic [INSN_W-1:0] data;
  } fetch_entry_t;

  function automatic logic [IP_W-1:0] align_ip(input logic [IP_W-1:0] ip);
    return ip & IP_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/insn_fetch_fifo.sv
// Prefetch FIFO of {addr, data} entries; flush wins over push and pop.
module fetch_fifo
  import insn_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             push_entry,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  fetch_entry_t     slots [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < DEPTH_CNT) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= push_entry;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign head  = slots[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch: owns the fetch pointer, issues single-outstanding memory reads,
// and feeds the decoder from a prefetch FIFO with redirect-driven flushes.
module insn_fetch
  import insn_fetch_pkg::*;
#(
  parameter logic [IP_W-1:0] RESET_IP = 16'h0000,
  parameter int              DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [IP_W-1:0]   redirect_addr,
  output logic              mem_req,
  output logic [IP_W-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [INSN_W-1:0] mem_rdata,
  output logic [INSN_W-1:0] insn,
  output logic [IP_W-1:0]   insn_addr,
  output logic              insn_valid,
  input  logic              insn_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [IP_W-1:0]  RESET_IP_ALIGNED = RESET_IP & IP_ALIGN_MASK;

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [IP_W-1:0]  fetch_ip;
  logic [IP_W-1:0]  fetch_ip_next;
  logic [IP_W-1:0]  mem_addr_next;
  logic             mem_req_next;
  logic             issue;
  logic             ack_live;
  logic             bus_free;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;
  logic             fifo_empty;

  // An ack only means something while a request is outstanding; a stray ack in IDLE is ignored.
  assign ack_live   = mem_ack && (state != IDLE);
  assign bus_free   = (state == IDLE) || ack_live;
  assign pop        = insn_valid && insn_ready && !redirect;
  assign push       = ack_live && (state == BUSY) && !redirect;
  assign push_entry = '{addr: fetch_ip, data: mem_rdata};

  always_comb begin
    count_next = count;
    if (redirect) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A new read goes out only once the bus is free and the FIFO will still have room for its data.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    if (bus_free) begin
      issue      = (count_next < DEPTH_CNT);
      state_next = issue ? BUSY : IDLE;
    end else if (redirect) begin
      state_next = DROP;
    end
  end

  always_comb begin
    fetch_ip_next = fetch_ip;
    if (redirect) begin
      fetch_ip_next = align_ip(redirect_addr);
    end else if (push) begin
      fetch_ip_next = fetch_ip + IP_W'(2);
    end
    mem_req_next  = issue || !bus_free;
    mem_addr_next = issue ? fetch_ip_next : mem_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req  <= 1'b0;
      mem_addr <= RESET_IP_ALIGNED;
      fetch_ip <= RESET_IP_ALIGNED;
    end else begin
      mem_req  <= mem_req_next;
      mem_addr <= mem_addr_next;
      fetch_ip <= fetch_ip_next;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_entry(push_entry),
    .head      (head),
    .count     (count),
    .empty     (fifo_empty)
  );

  assign insn_valid = !fifo_empty;
  assign insn       = head.data;
  assign insn_addr  = head.addr;

endmodule
